mips32_mem_arbiter: RTL and testbench
=====================================

Name: mips32_mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between three requesters: instruction fetch (IF stage), the data-memory access in the MEM stage (load/store), and a debug/loader port used by benches to preload programs and read results.
- Sits between the pipeline and the memory array.
- Provides fixed priority with IF anti-starvation, and one command per cycle.
- Tracks in-flight reads so each read response is routed back to the requester that issued it.

Parameters:
- ADDR_W, 10, word-address width (1024 x 32-bit words)
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles from command to mem_rdata valid (legal 1..4)
- STARVE_LIMIT, 4, consecutive denied IF cycles after which IF outranks the data port

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- halted  in  1  CPU halted; IF requests are not granted while high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch granted this cycle
- if_stall  out  1  if_req & ~if_gnt & ~halted
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request granted
- dbg_req  in  1  debug request
- dbg_we  in  1  debug write
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug granted
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read command
- rdata  out  DATA_W  read data broadcast to all requesters
- if_rvalid / dm_rvalid / dbg_rvalid  out  1 each  rdata belongs to that requester this cycle

Behaviour:
- Grants are combinational from the current-cycle requests and internal state. At most one gnt is high per cycle.
- mem_en/we/addr/wdata are a combinational mux of the granted request. When there is no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Handshake: a requester holds req, addr, we and wdata stable until it sees gnt high. The transfer completes in the gnt cycle. Dropping req before gnt is legal and has no side effects.
- Priority, normal: dbg > dm > IF.
- Priority, starved (starve_cnt == STARVE_LIMIT and if_req & ~halted): dbg > IF > dm.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - reset or clear → 0;
  - clears when if_gnt, ~if_req or halted;
  - otherwise increments when if_req & ~if_gnt;
  - saturates at STARVE_LIMIT.
- halted=1: if_gnt forced 0; the dm and dbg ports still operate (bench read-back after HALT).
- Response pipeline: a shift register of MEM_LAT entries, each holding {valid, src[1:0]}.
  - Stage 0 is loaded each cycle with valid = gnt & ~we, src = the granted source.
  - At the output stage: <src>_rvalid = valid & (src match); rdata = mem_rdata whenever any rvalid is high, else 0.
  - Writes never produce an rvalid.
  - A read granted in cycle N yields its rvalid in cycle N+MEM_LAT.
- Back-to-back reads from any mix of sources are fully pipelined, one per cycle; order is preserved.
- Reset values (synchronous): all pipeline entries invalid, starve_cnt=0. All rvalid=0 and rdata=0 in the cycle after reset is sampled.
- Reset mid-operation: in-flight reads are dropped; no rvalid appears for them.
- Simultaneous read and write to the same address in consecutive cycles: resolved purely in grant order; the arbiter performs no forwarding.

Decomposition:
- Shared package mips32_mem_pkg holds:
  - source encoding SRC_IF=0, SRC_DM=1, SRC_DBG=2;
  - the response-tag struct {valid, src};
  - ADDR_W and DATA_W defaults.
- One natural sub-module, mips32_rsp_tag_pipe: a MEM_LAT-deep tag shift register with synchronous reset. The grant and starvation logic stay in the top module.

Test Plan:
- Reset, then if_req=1 with if_addr=0, halted=0, MEM_LAT=1 → if_gnt=1 same cycle. Next cycle if_rvalid=1 and rdata=Mem[0] (0x20C10000).
- dm_req load addr 120 and if_req together, three cycles in a row, STARVE_LIMIT=4 → dm_gnt on every cycle; if_stall=1; starve_cnt reaches 3; no IF grant yet.
- dm_req held continuously with if_req=1 → after 4 denied IF cycles, if_gnt=1 on the 5th cycle and dm_gnt=0 there; starve_cnt then returns to 0.
- halted=1, if_req=1, dbg_req write addr 122 data 0x5A, then a dbg read of 122 → if_gnt stays 0. The write gives no rvalid. The read gives dbg_rvalid=1 with rdata=0x5A MEM_LAT cycles after its grant.
- MEM_LAT=3: interleaved reads IF@0, DM@120, DBG@121 in consecutive cycles → if/dm/dbg_rvalid in cycles 3, 4, 5 with rdata 0x20C10000, 0x14, 0x46.
- Two reads in flight, then reset asserted for 1 cycle → no rvalid in any cycle after reset; mem_en=0 while there are no requests.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter and its tag pipeline.
package mips32_mem_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 32;

  // Requester that owns an in-flight read
  typedef enum logic [1:0] {
    SRC_IF  = 2'd0,
    SRC_DM  = 2'd1,
    SRC_DBG = 2'd2
  } src_e;

  // One response-pipeline entry
  typedef struct packed {
    logic valid;
    src_e src;
  } rsp_tag_t;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the requesters/memory (master side) and the arbiter (slave side).
interface mips32_mem_arbiter_if
  import mips32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              halted;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata;
  logic              if_rvalid;
  logic              dm_rvalid;
  logic              dbg_rvalid;

  modport master (
    output halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  if_gnt, if_stall, dm_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
           rdata, if_rvalid, dm_rvalid, dbg_rvalid
  );

  modport slave (
    input  halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output if_gnt, if_stall, dm_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
           rdata, if_rvalid, dm_rvalid, dbg_rvalid
  );

endinterface

// File: rtl/mips32_rsp_tag_pipe.sv
// MEM_LAT-deep shift register of read tags; the output stage lines up with mem_rdata.
module mips32_rsp_tag_pipe
  import mips32_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic     clock,
  input  logic     reset,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage_q [MEM_LAT];

  // Shift tags one stage per cycle; reset drops everything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_LAT); i++) begin
        stage_q[i] <= rsp_tag_t'('0);
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter: dbg > dm > IF, with IF promoted above dm after
// STARVE_LIMIT consecutive denied cycles. Read responses are tagged by source.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clock,
  input logic                 reset,
  mips32_mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic              if_ok;
  logic              starved;
  logic              if_gnt;
  logic              dm_gnt;
  logic              dbg_gnt;
  logic              cmd_en;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CntW-1:0]   starve_cnt_q;
  logic [CntW-1:0]   starve_cnt_d;
  rsp_tag_t          tag_in;
  rsp_tag_t          tag_out;
  logic              any_rvalid;

  assign if_ok   = bus.if_req & ~bus.halted;
  assign starved = if_ok && (starve_cnt_q == CntW'(STARVE_LIMIT));

  // Grant selection: debug always wins; a starved fetch jumps ahead of data
  always_comb begin
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (bus.dbg_req) begin
      dbg_gnt = 1'b1;
    end else if (starved) begin
      if_gnt = 1'b1;
    end else if (bus.dm_req) begin
      dm_gnt = 1'b1;
    end else if (if_ok) begin
      if_gnt = 1'b1;
    end
  end

  // Memory command mux and read-tag generation from the single grant
  always_comb begin
    cmd_en     = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    tag_in     = rsp_tag_t'('0);
    if (dbg_gnt) begin
      cmd_en     = 1'b1;
      cmd_we     = bus.dbg_we;
      cmd_addr   = bus.dbg_addr;
      cmd_wdata  = bus.dbg_wdata;
      tag_in.src = SRC_DBG;
    end else if (dm_gnt) begin
      cmd_en     = 1'b1;
      cmd_we     = bus.dm_we;
      cmd_addr   = bus.dm_addr;
      cmd_wdata  = bus.dm_wdata;
      tag_in.src = SRC_DM;
    end else if (if_gnt) begin
      cmd_en     = 1'b1;
      cmd_addr   = bus.if_addr;
      tag_in.src = SRC_IF;
    end
    tag_in.valid = cmd_en & ~cmd_we;
  end

  // Starvation counter next state: clears on any fetch grant, idle or halt
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !bus.if_req || bus.halted) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CntW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mips32_rsp_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.if_stall  = bus.if_req & ~if_gnt & ~bus.halted;
  assign bus.mem_en    = cmd_en;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;

  assign bus.if_rvalid  = tag_out.valid && (tag_out.src == SRC_IF);
  assign bus.dm_rvalid  = tag_out.valid && (tag_out.src == SRC_DM);
  assign bus.dbg_rvalid = tag_out.valid && (tag_out.src == SRC_DBG);
  assign any_rvalid     = bus.if_rvalid | bus.dm_rvalid | bus.dbg_rvalid;
  assign bus.rdata      = any_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) each in front of a small memory model.
module tb_mips32_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
  mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b2 ();

  mips32_mem_arbiter #(
    .ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  mips32_mem_arbiter #(
    .ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)
  ) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (b2)
  );

  // Memory models; non-read cycles return a marker so rdata gating is visible
  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic [31:0] rd1;
  logic [31:0] rd2_p0, rd2_p1, rd2_p2;

  always @(posedge clock) begin
    if (reset) begin
      mem1[0]   <= 32'h20C1_0000;
      mem1[120] <= 32'h0000_0014;
      mem1[121] <= 32'h0000_0046;
      rd1       <= 32'hDEAD_BEEF;
    end else begin
      if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      rd1 <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      mem2[0]   <= 32'h20C1_0000;
      mem2[120] <= 32'h0000_0014;
      mem2[121] <= 32'h0000_0046;
      rd2_p0    <= 32'hDEAD_BEEF;
      rd2_p1    <= 32'hDEAD_BEEF;
      rd2_p2    <= 32'hDEAD_BEEF;
    end else begin
      if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr] <= b2.mem_wdata;
      rd2_p0 <= (b2.mem_en && !b2.mem_we) ? mem2[b2.mem_addr] : 32'hDEAD_BEEF;
      rd2_p1 <= rd2_p0;
      rd2_p2 <= rd2_p1;
    end
  end

  assign b1.mem_rdata = rd1;
  assign b2.mem_rdata = rd2_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    b1.halted = 1'b0; b1.if_req = 1'b0; b1.if_addr = '0;
    b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b1.dbg_req = 1'b0; b1.dbg_we = 1'b0; b1.dbg_addr = '0; b1.dbg_wdata = '0;
    b2.halted = 1'b0; b2.if_req = 1'b0; b2.if_addr = '0;
    b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = '0; b2.dm_wdata = '0;
    b2.dbg_req = 1'b0; b2.dbg_we = 1'b0; b2.dbg_addr = '0; b2.dbg_wdata = '0;
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    tick();
    tick();
    #1;
    // Reset state
    check("rst_rvalid", {29'd0, b1.if_rvalid, b1.dm_rvalid, b1.dbg_rvalid}, 32'd0);
    check("rst_rdata", b1.rdata, 32'd0);
    check("rst_mem_en", {31'd0, b1.mem_en}, 32'd0);
    check("rst_starve", 32'(dut1.starve_cnt_q), 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch, MEM_LAT=1
    b1.if_req = 1'b1; b1.if_addr = 10'd0;
    #1;
    check("t1_if_gnt", {31'd0, b1.if_gnt}, 32'd1);
    check("t1_mem_addr", {22'd0, b1.mem_addr}, 32'd0);
    check("t1_if_stall", {31'd0, b1.if_stall}, 32'd0);
    tick();
    b1.if_req = 1'b0;
    #1;
    check("t1_if_rvalid", {31'd0, b1.if_rvalid}, 32'd1);
    check("t1_rdata", b1.rdata, 32'h20C1_0000);
    tick();

    // Data port outranks fetch; fetch starves
    b1.if_req = 1'b1; b1.if_addr = 10'd0;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 10'd120;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_starve", 32'(dut1.starve_cnt_q), k);
      check("t2_dm_gnt", {31'd0, b1.dm_gnt}, 32'd1);
      check("t2_if_gnt", {31'd0, b1.if_gnt}, 32'd0);
      check("t2_if_stall", {31'd0, b1.if_stall}, 32'd1);
      check("t2_mem_addr", {22'd0, b1.mem_addr}, 32'd120);
      if (k > 0) begin
        check("t2_dm_rvalid", {31'd0, b1.dm_rvalid}, 32'd1);
        check("t2_dm_rdata", b1.rdata, 32'h0000_0014);
      end
      tick();
    end
    #1;
    // Fifth cycle: starved fetch wins over data
    check("t3_starve_sat", 32'(dut1.starve_cnt_q), 32'd4);
    check("t3_if_gnt", {31'd0, b1.if_gnt}, 32'd1);
    check("t3_dm_gnt", {31'd0, b1.dm_gnt}, 32'd0);
    check("t3_mem_addr", {22'd0, b1.mem_addr}, 32'd0);
    tick();
    #1;
    check("t3_starve_clr", 32'(dut1.starve_cnt_q), 32'd0);
    check("t3_if_rvalid", {31'd0, b1.if_rvalid}, 32'd1);
    check("t3_if_rdata", b1.rdata, 32'h20C1_0000);
    check("t3_dm_gnt_back", {31'd0, b1.dm_gnt}, 32'd1);
    idle_all();
    tick();
    tick();

    // Halted: fetch blocked, debug write then read-back
    b1.halted = 1'b1; b1.if_req = 1'b1; b1.if_addr = 10'd0;
    b1.dbg_req = 1'b1; b1.dbg_we = 1'b1; b1.dbg_addr = 10'd122; b1.dbg_wdata = 32'h5A;
    #1;
    check("t4_dbg_gnt_w", {31'd0, b1.dbg_gnt}, 32'd1);
    check("t4_if_gnt_w", {31'd0, b1.if_gnt}, 32'd0);
    check("t4_if_stall_h", {31'd0, b1.if_stall}, 32'd0);
    check("t4_mem_we", {31'd0, b1.mem_we}, 32'd1);
    check("t4_mem_wdata", b1.mem_wdata, 32'h5A);
    tick();
    b1.dbg_we = 1'b0;
    #1;
    check("t4_dbg_gnt_r", {31'd0, b1.dbg_gnt}, 32'd1);
    check("t4_mem_we_r", {31'd0, b1.mem_we}, 32'd0);
    check("t4_no_wr_rvalid", {29'd0, b1.if_rvalid, b1.dm_rvalid, b1.dbg_rvalid}, 32'd0);
    tick();
    b1.dbg_req = 1'b0;
    #1;
    check("t4_dbg_rvalid", {31'd0, b1.dbg_rvalid}, 32'd1);
    check("t4_dbg_rdata", b1.rdata, 32'h5A);
    check("t4_if_gnt_h", {31'd0, b1.if_gnt}, 32'd0);
    check("t4_mem_en_h", {31'd0, b1.mem_en}, 32'd0);
    tick();
    #1;
    check("t4_rdata_idle", b1.rdata, 32'd0);
    idle_all();
    tick();

    // MEM_LAT=3 interleaved reads
    b2.if_req = 1'b1; b2.if_addr = 10'd0;
    #1;
    check("t5_if_gnt", {31'd0, b2.if_gnt}, 32'd1);
    tick();
    b2.if_req = 1'b0;
    b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 10'd120;
    #1;
    check("t5_dm_gnt", {31'd0, b2.dm_gnt}, 32'd1);
    tick();
    b2.dm_req = 1'b0;
    b2.dbg_req = 1'b1; b2.dbg_we = 1'b0; b2.dbg_addr = 10'd121;
    #1;
    check("t5_dbg_gnt", {31'd0, b2.dbg_gnt}, 32'd1);
    check("t5_no_early", {29'd0, b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 32'd0);
    tick();
    b2.dbg_req = 1'b0;
    #1;
    check("t5_rv_c3", {29'd0, b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 32'b100);
    check("t5_rd_c3", b2.rdata, 32'h20C1_0000);
    tick();
    #1;
    check("t5_rv_c4", {29'd0, b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 32'b010);
    check("t5_rd_c4", b2.rdata, 32'h0000_0014);
    tick();
    #1;
    check("t5_rv_c5", {29'd0, b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 32'b001);
    check("t5_rd_c5", b2.rdata, 32'h0000_0046);
    tick();

    // Reset with two reads in flight drops their responses
    b2.if_req = 1'b1; b2.if_addr = 10'd0;
    tick();
    b2.if_req = 1'b0;
    b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 10'd120;
    tick();
    b2.dm_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6_rvalid2", {29'd0, b2.if_rvalid, b2.dm_rvalid, b2.dbg_rvalid}, 32'd0);
      check("t6_rdata2", b2.rdata, 32'd0);
      check("t6_mem_en2", {31'd0, b2.mem_en}, 32'd0);
      check("t6_rvalid1", {29'd0, b1.if_rvalid, b1.dm_rvalid, b1.dbg_rvalid}, 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
